// File: rtl/mips_core_pkg.sv
// Shared core-wide sizing constants and the reorder-buffer entry layout.
package mips_core_pkg;

  localparam int ROB_DEPTH          = 16;
  localparam int ROB_TAG_WIDTH      = $clog2(ROB_DEPTH);
  localparam int PHY_REG_ADDR_WIDTH = 6;
  localparam int DATA_WIDTH         = 32;

  typedef struct packed {
    logic                          valid;
    logic                          done;
    logic                          has_dest;
    logic [PHY_REG_ADDR_WIDTH-1:0] phy_dest;
    logic [DATA_WIDTH-1:0]         data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries allocate at tail, complete out of order,
// and retire one per cycle from head with a registered register-file write.
module reorder_buffer #(
  parameter int ROB_DEPTH          = mips_core_pkg::ROB_DEPTH,
  parameter int PHY_REG_ADDR_WIDTH = mips_core_pkg::PHY_REG_ADDR_WIDTH,
  parameter int DATA_WIDTH         = mips_core_pkg::DATA_WIDTH,
  localparam int TAG_W             = $clog2(ROB_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic                          alloc_has_dest,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] alloc_phy_dest,
  output logic [TAG_W-1:0]              alloc_tag,
  input  logic                          cmpl_valid,
  input  logic [TAG_W-1:0]              cmpl_tag,
  input  logic [DATA_WIDTH-1:0]         cmpl_data,
  input  logic                          flush,
  output logic                          reg_wr_en,
  output logic [PHY_REG_ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0]         reg_wr_data,
  output logic                          commit_valid,
  output logic [TAG_W-1:0]              commit_tag,
  output logic [TAG_W:0]                count
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0]          valid_q;
  logic [ROB_DEPTH-1:0]          done_q;
  logic [ROB_DEPTH-1:0]          has_dest_q;
  logic [PHY_REG_ADDR_WIDTH-1:0] phy_dest_q [ROB_DEPTH];
  logic [DATA_WIDTH-1:0]         data_q     [ROB_DEPTH];

  logic [TAG_W-1:0]              head_q, tail_q;
  logic [TAG_W:0]                count_q;

  logic                          commit_valid_q;
  logic [TAG_W-1:0]              commit_tag_q;
  logic                          reg_wr_en_q;
  logic [PHY_REG_ADDR_WIDTH-1:0] reg_wr_addr_q;
  logic [DATA_WIDTH-1:0]         reg_wr_data_q;

  logic alloc_fire;
  logic commit_fire;
  logic cmpl_fire;

  // Readiness uses registered occupancy only; a retiring entry frees a slot next cycle.
  assign alloc_ready = (count_q < FULL_CNT);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = valid_q[head_q] && done_q[head_q];
  assign cmpl_fire   = cmpl_valid && valid_q[cmpl_tag];

  assign alloc_tag    = tail_q;
  assign count        = count_q;
  assign commit_valid = commit_valid_q;
  assign commit_tag   = commit_tag_q;
  assign reg_wr_en    = reg_wr_en_q;
  assign reg_wr_addr  = reg_wr_addr_q;
  assign reg_wr_data  = reg_wr_data_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      reg_wr_en_q    <= 1'b0;
      reg_wr_addr_q  <= '0;
      reg_wr_data_q  <= '0;
    end else begin
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      reg_wr_en_q    <= 1'b0;
      reg_wr_addr_q  <= '0;
      reg_wr_data_q  <= '0;

      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
        commit_valid_q  <= 1'b1;
        commit_tag_q    <= head_q;
        reg_wr_en_q     <= has_dest_q[head_q];
        reg_wr_addr_q   <= phy_dest_q[head_q];
        reg_wr_data_q   <= data_q[head_q];
      end

      if (cmpl_fire) begin
        done_q[cmpl_tag] <= 1'b1;
      end

      // The tail slot is never valid when allocation fires, so it cannot
      // collide with the commit or completion updates above.
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end

      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage is unreset; stale contents are masked by the valid bits.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      has_dest_q[tail_q] <= alloc_has_dest;
      phy_dest_q[tail_q] <= alloc_phy_dest;
    end
    if (cmpl_fire) begin
      data_q[cmpl_tag] <= cmpl_data;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order retirement, full/wrap handling,
// no-destination entries, and flush/reset discarding in-flight work.
module tb_reorder_buffer;

  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_has_dest;
  logic [5:0]        alloc_phy_dest;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cmpl_valid;
  logic [TAG_W-1:0]  cmpl_tag;
  logic [31:0]       cmpl_data;
  logic              flush;
  logic              reg_wr_en;
  logic [5:0]        reg_wr_addr;
  logic [31:0]       reg_wr_data;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic [TAG_W:0]    count;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_has_dest (alloc_has_dest),
    .alloc_phy_dest (alloc_phy_dest),
    .alloc_tag      (alloc_tag),
    .cmpl_valid     (cmpl_valid),
    .cmpl_tag       (cmpl_tag),
    .cmpl_data      (cmpl_data),
    .flush          (flush),
    .reg_wr_en      (reg_wr_en),
    .reg_wr_addr    (reg_wr_addr),
    .reg_wr_data    (reg_wr_data),
    .commit_valid   (commit_valid),
    .commit_tag     (commit_tag),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_has_dest = 1'b0; alloc_phy_dest = '0;
    cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_data = '0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic has_dest, input logic [5:0] dest);
    alloc_valid = 1'b1; alloc_has_dest = has_dest; alloc_phy_dest = dest;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic complete(input logic [TAG_W-1:0] tag, input logic [31:0] data);
    cmpl_valid = 1'b1; cmpl_tag = tag; cmpl_data = data;
    tick();
    cmpl_valid = 1'b0;
  endtask

  initial begin
    logic [TAG_W-1:0] prev;

    // Reset state
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(alloc_ready), 32'd1);
    check("rst_cv", 32'(commit_valid), 32'd0);
    check("rst_wen", 32'(reg_wr_en), 32'd0);
    check("rst_tag", 32'(alloc_tag), 32'd0);

    // Single alloc / complete / commit with one-cycle latency
    check("t1_alloc_tag", 32'(alloc_tag), 32'd0);
    alloc(1'b1, 6'd5);
    check("t1_count", 32'(count), 32'd1);
    complete(4'd0, 32'hDEADBEEF);
    check("t1_no_commit_yet", 32'(commit_valid), 32'd0);
    tick();
    check("t1_cv", 32'(commit_valid), 32'd1);
    check("t1_wen", 32'(reg_wr_en), 32'd1);
    check("t1_addr", 32'(reg_wr_addr), 32'd5);
    check("t1_data", reg_wr_data, 32'hDEADBEEF);
    check("t1_ctag", 32'(commit_tag), 32'd0);
    check("t1_count_after", 32'(count), 32'd0);
    tick();
    check("t1_cv_deassert", 32'(commit_valid), 32'd0);
    check("t1_data_zero", reg_wr_data, 32'd0);

    // Out-of-order completion retires in program order
    do_reset();
    alloc(1'b1, 6'd10);
    alloc(1'b1, 6'd11);
    alloc(1'b1, 6'd12);
    complete(4'd2, 32'd2);
    check("t2_hold_after2", 32'(commit_valid), 32'd0);
    complete(4'd1, 32'd1);
    check("t2_hold_after1", 32'(commit_valid), 32'd0);
    complete(4'd0, 32'h100);
    check("t2_hold_after0", 32'(commit_valid), 32'd0);
    tick();
    check("t2_c0_tag", 32'(commit_tag), 32'd0);
    check("t2_c0_addr", 32'(reg_wr_addr), 32'd10);
    check("t2_c0_data", reg_wr_data, 32'h100);
    tick();
    check("t2_c1_tag", 32'(commit_tag), 32'd1);
    check("t2_c1_data", reg_wr_data, 32'd1);
    tick();
    check("t2_c2_tag", 32'(commit_tag), 32'd2);
    check("t2_c2_addr", 32'(reg_wr_addr), 32'd12);
    tick();
    check("t2_idle_cv", 32'(commit_valid), 32'd0);
    check("t2_count", 32'(count), 32'd0);

    // Fill to capacity, overflow attempt, ready returns after a commit
    do_reset();
    for (int i = 0; i < 16; i++) alloc(1'b1, 6'(i + 20));
    check("t3_ready_full", 32'(alloc_ready), 32'd0);
    check("t3_count_full", 32'(count), 32'd16);
    alloc(1'b1, 6'd63);
    check("t3_ovf_count", 32'(count), 32'd16);
    check("t3_ovf_tag", 32'(alloc_tag), 32'd0);
    complete(4'd0, 32'hA0);
    check("t3_ready_before_commit", 32'(alloc_ready), 32'd0);
    tick();
    check("t3_commit_addr", 32'(reg_wr_addr), 32'd20);
    check("t3_commit_data", reg_wr_data, 32'hA0);
    check("t3_ready_after", 32'(alloc_ready), 32'd1);
    check("t3_count_after", 32'(count), 32'd15);

    // Refill across the wrap point and drain in order 1..15, 0
    check("t4_wrap_tag", 32'(alloc_tag), 32'd0);
    alloc(1'b1, 6'd40);
    check("t4_count_full", 32'(count), 32'd16);
    for (int k = 1; k <= 16; k++) begin
      complete(4'(k % 16), 32'h200 + 32'(k % 16));
      if (k > 1) begin
        prev = 4'(k - 1);
        check("t4_drain_tag", 32'(commit_tag), 32'(prev));
        check("t4_drain_data", reg_wr_data, 32'h200 + 32'(prev));
        check("t4_drain_addr", 32'(reg_wr_addr), 32'(prev) + 32'd20);
      end
    end
    tick();
    check("t4_last_tag", 32'(commit_tag), 32'd0);
    check("t4_last_addr", 32'(reg_wr_addr), 32'd40);
    check("t4_last_data", reg_wr_data, 32'h200);
    check("t4_count_empty", 32'(count), 32'd0);

    // Entry without a destination retires without a register write
    do_reset();
    alloc(1'b0, 6'd7);
    complete(4'd0, 32'h55);
    tick();
    check("t5_cv", 32'(commit_valid), 32'd1);
    check("t5_wen", 32'(reg_wr_en), 32'd0);

    // Flush overrides a simultaneous commit and allocation
    do_reset();
    alloc(1'b1, 6'd3);
    complete(4'd0, 32'h77);
    flush = 1'b1; alloc_valid = 1'b1; alloc_has_dest = 1'b1; alloc_phy_dest = 6'd9;
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    check("t6_flush_wen", 32'(reg_wr_en), 32'd0);
    check("t6_flush_cv", 32'(commit_valid), 32'd0);
    check("t6_flush_count", 32'(count), 32'd0);
    check("t6_flush_tag", 32'(alloc_tag), 32'd0);
    tick();
    check("t6_flush_later_cv", 32'(commit_valid), 32'd0);

    // Reset mid-stream behaves the same way
    alloc(1'b1, 6'd4);
    complete(4'd0, 32'h88);
    rst = 1'b1; alloc_valid = 1'b1;
    tick();
    rst = 1'b0; alloc_valid = 1'b0;
    check("t7_rst_wen", 32'(reg_wr_en), 32'd0);
    check("t7_rst_count", 32'(count), 32'd0);
    check("t7_rst_tag", 32'(alloc_tag), 32'd0);
    tick();
    check("t7_rst_later_cv", 32'(commit_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
